game_round_fsm: RTL

Top-level game sequencer for the whack-a-mole design; the parametrised successor of the single-round start/play/done controller. It adds a pre-game countdown, multiple timed rounds with inter-round breaks, a pause button, and an internal seconds counter driven by an external 1 Hz tick. It gates the mole generator and hit logic through `game_active`, and clears the score and timers through `sys_reset`.

---
 rtl/game_pkg.sv | 22 ++
 rtl/btn_edge.sv | 22 ++
 rtl/game_round_fsm.sv | 138 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: state encoding used by the sequencer, display and debug logic,
// plus a small helper for sizing the seconds counter.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_BREAK     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-debounced, synchronous button level.
// The previous-sample flop resets to RESET_VAL so a button held through reset is not a press.
module btn_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic prev;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= RESET_VAL;
    else          prev <= btn;
  end

  assign press = btn & ~prev;

endmodule

// File: rtl/game_round_fsm.sv
// Whack-a-mole game sequencer: countdown, timed rounds with breaks, pause, and abort.
// All outputs are registered from the next-state values, so they change on the same edge as the state.
module game_round_fsm
  import game_pkg::*;
#(
  parameter int  COUNTDOWN_SECS = 3,
  parameter int  ROUND_SECS     = 30,
  parameter int  BREAK_SECS     = 2,
  parameter int  NUM_ROUNDS     = 3,
  localparam int SECS_W  = $clog2(max3(COUNTDOWN_SECS, ROUND_SECS, BREAK_SECS) + 1),
  localparam int ROUND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               tick_1hz,
  output logic               game_active,
  output logic               sys_reset,
  output logic               round_start,
  output logic               game_over,
  output logic [SECS_W-1:0]  secs_left,
  output logic [ROUND_W-1:0] round_idx,
  output logic [STATE_W-1:0] state_debug
);

  logic start_press, pause_press;

  btn_edge #(.RESET_VAL(1'b1)) u_start_edge (
    .clk(clk), .reset_n(reset_n), .btn(start_btn), .press(start_press)
  );

  btn_edge #(.RESET_VAL(1'b1)) u_pause_edge (
    .clk(clk), .reset_n(reset_n), .btn(pause_btn), .press(pause_press)
  );

  state_t             state, state_n;
  logic [SECS_W-1:0]  secs_n;
  logic [ROUND_W-1:0] round_n;
  logic               enter_play, enter_done;

  // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
  always_comb begin
    state_n    = state;
    secs_n     = secs_left;
    round_n    = round_idx;
    enter_play = 1'b0;
    enter_done = 1'b0;

    if (start_press) begin
      // Start is both "new game" from IDLE and "abort" from anywhere else.
      round_n = '0;
      if (state == S_IDLE) begin
        state_n = S_COUNTDOWN;
        secs_n  = SECS_W'(COUNTDOWN_SECS);
      end else begin
        state_n = S_IDLE;
        secs_n  = '0;
      end
    end else begin
      case (state)
        S_IDLE: ;
        S_COUNTDOWN: begin
          if (tick_1hz) begin
            if (secs_left <= SECS_W'(1)) begin
              state_n    = S_PLAY;
              secs_n     = SECS_W'(ROUND_SECS);
              enter_play = 1'b1;
            end else begin
              secs_n = secs_left - SECS_W'(1);
            end
          end
        end
        S_PLAY: begin
          // A pause press swallows a coincident tick.
          if (pause_press) begin
            state_n = S_PAUSE;
          end else if (tick_1hz) begin
            if (secs_left > SECS_W'(1)) begin
              secs_n = secs_left - SECS_W'(1);
            end else if (round_idx == ROUND_W'(NUM_ROUNDS - 1)) begin
              state_n    = S_DONE;
              secs_n     = '0;
              enter_done = 1'b1;
            end else begin
              state_n = S_BREAK;
              secs_n  = SECS_W'(BREAK_SECS);
            end
          end
        end
        S_PAUSE: begin
          if (pause_press) state_n = S_PLAY;
        end
        S_BREAK: begin
          if (tick_1hz) begin
            if (secs_left <= SECS_W'(1)) begin
              state_n    = S_PLAY;
              secs_n     = SECS_W'(ROUND_SECS);
              round_n    = round_idx + ROUND_W'(1);
              enter_play = 1'b1;
            end else begin
              secs_n = secs_left - SECS_W'(1);
            end
          end
        end
        S_DONE: secs_n = '0;
        default: begin
          state_n = S_IDLE;
          secs_n  = '0;
          round_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      secs_left   <= '0;
      round_idx   <= '0;
      round_start <= 1'b0;
      game_over   <= 1'b0;
      game_active <= 1'b0;
      sys_reset   <= 1'b1;
      state_debug <= S_IDLE;
    end else begin
      state       <= state_n;
      secs_left   <= secs_n;
      round_idx   <= round_n;
      round_start <= enter_play;
      game_over   <= enter_done;
      game_active <= (state_n == S_PLAY);
      sys_reset   <= (state_n == S_IDLE);
      state_debug <= state_n;
    end
  end

endmodule
